// File: rtl/hazard_sched_if.sv
// -----------------------------------------------------------------------------
// hazard_sched_if
//   Bundles the hazard-detection inputs and the pipeline-control outputs of the
//   hazard scheduler into one interface.
//
//   Hazard inputs (stage suffix gives the stage the instruction sits in):
//     Rs1_D, Rs2_D, Rs1Used_D, Rs2Used_D   source operands of the instruction in D
//     Rdst_E, RegWrEn_E (active-low), IsLoad_E, BranchTaken_E   instruction in E
//     MemReq_M, MemReady_M                  data-memory access of the instruction in M
//     halt_W                                halt instruction has reached WB
//   Control outputs:
//     PC_WEN, WEN_pipe (both active-low), stall_FD, nop_FD, stall_DE, nop_DE,
//     nop_EM, halted, mem_timeout
//
//   modport slave  : the scheduler (consumes hazards, drives controls)
//   modport master : the core / environment (drives hazards, consumes controls)
// -----------------------------------------------------------------------------
interface hazard_sched_if;
  logic [4:0] Rs1_D;
  logic [4:0] Rs2_D;
  logic       Rs1Used_D;
  logic       Rs2Used_D;
  logic [4:0] Rdst_E;
  logic       RegWrEn_E;
  logic       IsLoad_E;
  logic       BranchTaken_E;
  logic       MemReq_M;
  logic       MemReady_M;
  logic       halt_W;

  logic       PC_WEN;
  logic       WEN_pipe;
  logic       stall_FD;
  logic       nop_FD;
  logic       stall_DE;
  logic       nop_DE;
  logic       nop_EM;
  logic       halted;
  logic       mem_timeout;

  modport slave (
    input  Rs1_D, Rs2_D, Rs1Used_D, Rs2Used_D, Rdst_E, RegWrEn_E, IsLoad_E,
           BranchTaken_E, MemReq_M, MemReady_M, halt_W,
    output PC_WEN, WEN_pipe, stall_FD, nop_FD, stall_DE, nop_DE, nop_EM,
           halted, mem_timeout
  );

  modport master (
    output Rs1_D, Rs2_D, Rs1Used_D, Rs2Used_D, Rdst_E, RegWrEn_E, IsLoad_E,
           BranchTaken_E, MemReq_M, MemReady_M, halt_W,
    input  PC_WEN, WEN_pipe, stall_FD, nop_FD, stall_DE, nop_DE, nop_EM,
           halted, mem_timeout
  );
endinterface

// File: rtl/hazard_sched.sv
// -----------------------------------------------------------------------------
// hazard_sched
//   Hazard scheduler for the 5-stage core. Sequences load-use bubbles,
//   taken-branch flushes, data-memory wait-state freezes and the halt drain,
//   and drives the stall / nop / write-enable controls of the pipeline
//   registers. State updates on posedge CLK; the pipeline registers sample the
//   (combinational) controls on the following negedge.
//
//   Ports:
//     CLK   clock
//     RST   synchronous reset, active-low; forces every control output to 0
//     bus   hazard_sched_if.slave (hazard inputs, control outputs)
//   Optional (macro HAZ_PERF_CNT_EN defined):
//     stall_cycles  cycles with stall_FD=1
//     flush_count   taken-branch flushes
//     wait_cycles   cycles spent in MEM_WAIT
//
//   Parameters:
//     LOAD_BUBBLES  bubbles per load-use hazard (1..3)
//     MAX_MEM_WAIT  wait cycles allowed before timeout (1..255)
//     CNT_W         performance counter width
// -----------------------------------------------------------------------------
module hazard_sched #(
  parameter int LOAD_BUBBLES = 1,
  parameter int MAX_MEM_WAIT = 15,
  parameter int CNT_W        = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
`ifdef HAZ_PERF_CNT_EN
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_count,
  output logic [CNT_W-1:0]     wait_cycles,
`endif
  hazard_sched_if.slave        bus
);

  // Reject illegal configurations at elaboration.
  if (LOAD_BUBBLES < 1 || LOAD_BUBBLES > 3) begin : g_bad_bubbles
    $error("hazard_sched: LOAD_BUBBLES must be 1..3");
  end
  if (MAX_MEM_WAIT < 1 || MAX_MEM_WAIT > 255) begin : g_bad_wait
    $error("hazard_sched: MAX_MEM_WAIT must be 1..255");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("hazard_sched: CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_LOAD_STALL = 2'd1,
    S_MEM_WAIT   = 2'd2,
    S_HALTED     = 2'd3
  } state_t;

  localparam logic [1:0] BUB_INIT = 2'(LOAD_BUBBLES - 1);
  localparam logic [7:0] WAIT_MAX = 8'(MAX_MEM_WAIT);

  state_t     r_state;
  logic [1:0] r_bub_cnt;
  logic [7:0] r_wait_cnt;
  logic       r_saved_ls;    // MEM_WAIT returns to LOAD_STALL when set
  logic       r_mem_timeout;

  state_t     w_next;
  logic [1:0] w_bub_nxt;
  logic [7:0] w_wait_nxt;
  logic       w_saved_nxt;
  logic       w_tmo_set;
  logic       w_luh;
  logic       w_mem_stall;
  logic       w_flush;

  logic       w_pc_wen;
  logic       w_wen_pipe;
  logic       w_stall_fd;
  logic       w_nop_fd;
  logic       w_nop_de;
  logic       w_halted;

  // Load in E writing a non-zero register that the instruction in D reads.
  assign w_luh = bus.IsLoad_E & ~bus.RegWrEn_E & (bus.Rdst_E != 5'd0) &
                 ((bus.Rs1Used_D & (bus.Rs1_D == bus.Rdst_E)) |
                  (bus.Rs2Used_D & (bus.Rs2_D == bus.Rdst_E)));

  assign w_mem_stall = bus.MemReq_M & ~bus.MemReady_M;

  always_comb begin
    w_next      = r_state;
    w_bub_nxt   = r_bub_cnt;
    w_wait_nxt  = r_wait_cnt;
    w_saved_nxt = r_saved_ls;
    w_tmo_set   = 1'b0;
    w_flush     = 1'b0;
    w_pc_wen    = 1'b0;
    w_wen_pipe  = 1'b0;
    w_stall_fd  = 1'b0;
    w_nop_fd    = 1'b0;
    w_nop_de    = 1'b0;
    w_halted    = 1'b0;

    if (RST) begin
      unique case (r_state)
        S_RUN, S_LOAD_STALL: begin
          if (bus.halt_W) begin
            // Drain complete: freeze everything from this cycle on.
            w_pc_wen   = 1'b1;
            w_wen_pipe = 1'b1;
            w_next     = S_HALTED;
          end else if (w_mem_stall) begin
            // Whole pipeline freezes; bubble counter is kept untouched so a
            // load stall resumes where it left off.
            w_pc_wen    = 1'b1;
            w_wen_pipe  = 1'b1;
            w_wait_nxt  = 8'd1;
            w_saved_nxt = (r_state == S_LOAD_STALL);
            w_next      = S_MEM_WAIT;
          end else if (bus.BranchTaken_E) begin
            // Squash the two wrong-path slots; any pending bubbles are moot.
            w_nop_fd  = 1'b1;
            w_nop_de  = 1'b1;
            w_flush   = 1'b1;
            w_bub_nxt = 2'd0;
            w_next    = S_RUN;
          end else if (r_state == S_LOAD_STALL) begin
            // Bubble count was fixed on entry; luh is not looked at here.
            w_pc_wen   = 1'b1;
            w_stall_fd = 1'b1;
            w_nop_de   = 1'b1;
            w_bub_nxt  = r_bub_cnt - 2'd1;
            if (r_bub_cnt <= 2'd1) w_next = S_RUN;
          end else if (w_luh) begin
            w_pc_wen   = 1'b1;
            w_stall_fd = 1'b1;
            w_nop_de   = 1'b1;
            if (LOAD_BUBBLES > 1) begin
              w_bub_nxt = BUB_INIT;
              w_next    = S_LOAD_STALL;
            end
          end
        end

        S_MEM_WAIT: begin
          // Still frozen in the ready cycle: the access completes first.
          w_pc_wen   = 1'b1;
          w_wen_pipe = 1'b1;
          if (bus.MemReady_M) begin
            w_next = r_saved_ls ? S_LOAD_STALL : S_RUN;
          end else if (r_wait_cnt >= WAIT_MAX) begin
            w_tmo_set = 1'b1;
            w_next    = S_HALTED;
          end else begin
            w_wait_nxt = r_wait_cnt + 8'd1;
          end
        end

        S_HALTED: begin
          w_pc_wen   = 1'b1;
          w_wen_pipe = 1'b1;
          w_halted   = 1'b1;
        end

        default: w_next = S_RUN;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state       <= S_RUN;
      r_bub_cnt     <= 2'd0;
      r_wait_cnt    <= 8'd0;
      r_saved_ls    <= 1'b0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_bub_cnt     <= w_bub_nxt;
      r_wait_cnt    <= w_wait_nxt;
      r_saved_ls    <= w_saved_nxt;
      r_mem_timeout <= r_mem_timeout | w_tmo_set;
    end
  end

  assign bus.PC_WEN      = w_pc_wen;
  assign bus.WEN_pipe    = w_wen_pipe;
  assign bus.stall_FD    = w_stall_fd;
  assign bus.nop_FD      = w_nop_fd;
  assign bus.stall_DE    = 1'b0;
  assign bus.nop_DE      = w_nop_de;
  assign bus.nop_EM      = 1'b0;
  assign bus.halted      = w_halted;
  assign bus.mem_timeout = RST & r_mem_timeout;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;
  logic [CNT_W-1:0] r_wait_cycles;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
      r_wait_cycles  <= '0;
    end else if (r_state != S_HALTED) begin
      if (w_stall_fd)              r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_flush)                 r_flush_count  <= r_flush_count + 1'b1;
      if (r_state == S_MEM_WAIT)   r_wait_cycles  <= r_wait_cycles + 1'b1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
  assign wait_cycles  = r_wait_cycles;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
module tb_hazard_sched;
  localparam int LB   = 2;
  localparam int MAXW = 4;

  // Expected output vector order:
  // {PC_WEN, WEN_pipe, stall_FD, nop_FD, stall_DE, nop_DE, nop_EM, halted, mem_timeout}
  localparam logic [8:0] O_NONE = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] O_LUS  = 9'b1_0_1_0_0_1_0_0_0;
  localparam logic [8:0] O_BR   = 9'b0_0_0_1_0_1_0_0_0;
  localparam logic [8:0] O_FRZ  = 9'b1_1_0_0_0_0_0_0_0;
  localparam logic [8:0] O_HLT  = 9'b1_1_0_0_0_0_0_1_0;
  localparam logic [8:0] O_TMO  = 9'b1_1_0_0_0_0_0_1_1;

  typedef enum logic [3:0] {
    K_IDLE, K_LUH, K_LUH_R0, K_LUH_NOUSE, K_LUH_NOWR, K_LUH_RS2,
    K_BR, K_BR_LUH, K_MWAIT, K_MRDY, K_HALT, K_HALT_MWAIT, K_ALL
  } kind_t;

  typedef struct {
    logic       rst_n;
    kind_t      kind;
    logic [8:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [8:0] sb_q[$];
  vec_t tbl[$];

  hazard_sched_if hif ();

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
  logic [31:0] wait_cycles;
`endif

  hazard_sched #(
    .LOAD_BUBBLES(LB),
    .MAX_MEM_WAIT(MAXW),
    .CNT_W(32)
  ) dut (
    .CLK(clk),
    .RST(rst_n),
`ifdef HAZ_PERF_CNT_EN
    .stall_cycles(stall_cycles),
    .flush_count(flush_count),
    .wait_cycles(wait_cycles),
`endif
    .bus(hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] outs();
    return {hif.PC_WEN, hif.WEN_pipe, hif.stall_FD, hif.nop_FD, hif.stall_DE,
            hif.nop_DE, hif.nop_EM, hif.halted, hif.mem_timeout};
  endfunction

  task automatic apply(input kind_t k);
    hif.Rs1_D = 5'd0; hif.Rs2_D = 5'd0; hif.Rs1Used_D = 1'b0; hif.Rs2Used_D = 1'b0;
    hif.Rdst_E = 5'd0; hif.RegWrEn_E = 1'b1; hif.IsLoad_E = 1'b0;
    hif.BranchTaken_E = 1'b0; hif.MemReq_M = 1'b0; hif.MemReady_M = 1'b0;
    hif.halt_W = 1'b0;
    if (k inside {K_LUH, K_LUH_R0, K_LUH_NOUSE, K_LUH_NOWR, K_BR_LUH, K_ALL}) begin
      hif.IsLoad_E = 1'b1; hif.RegWrEn_E = 1'b0; hif.Rdst_E = 5'd5;
      hif.Rs1_D = 5'd5; hif.Rs1Used_D = 1'b1;
    end
    case (k)
      K_LUH_R0:    begin hif.Rdst_E = 5'd0; hif.Rs1_D = 5'd0; end
      K_LUH_NOUSE: hif.Rs1Used_D = 1'b0;
      K_LUH_NOWR:  hif.RegWrEn_E = 1'b1;
      K_LUH_RS2:   begin
        hif.IsLoad_E = 1'b1; hif.RegWrEn_E = 1'b0; hif.Rdst_E = 5'd5;
        hif.Rs1_D = 5'd3; hif.Rs1Used_D = 1'b1; hif.Rs2_D = 5'd5; hif.Rs2Used_D = 1'b1;
      end
      K_BR, K_BR_LUH: hif.BranchTaken_E = 1'b1;
      K_MWAIT:     hif.MemReq_M = 1'b1;
      K_MRDY:      begin hif.MemReq_M = 1'b1; hif.MemReady_M = 1'b1; end
      K_HALT:      hif.halt_W = 1'b1;
      K_HALT_MWAIT: begin hif.halt_W = 1'b1; hif.MemReq_M = 1'b1; end
      K_ALL:       begin hif.BranchTaken_E = 1'b1; hif.MemReq_M = 1'b1; hif.halt_W = 1'b1; end
      default: ;
    endcase
  endtask

  task automatic check(input string nm, input int idx, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s[%0d] got %b want %b", nm, idx, got, want);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare at negedge.
  task automatic run_row(input string nm, input int idx, input logic r,
                         input kind_t k, input logic [8:0] e);
    logic [8:0] want;
    @(posedge clk);
    #1;
    rst_n = r;
    apply(k);
    sb_q.push_back(e);
    @(negedge clk);
    want = sb_q.pop_front();
    check(nm, idx, 32'(outs()), 32'(want));
  endtask

  function automatic vec_t mkv(input logic r, input kind_t k, input logic [8:0] e);
    vec_t v;
    v.rst_n = r; v.kind = k; v.exp = e;
    return v;
  endfunction

  initial begin
    int n;
    bit done;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    apply(K_IDLE);

    // reset forces outputs to 0 even with every hazard raised
    tbl.push_back(mkv(0, K_ALL, O_NONE));
    tbl.push_back(mkv(0, K_ALL, O_NONE));
    tbl.push_back(mkv(1, K_IDLE, O_NONE));
    // two-bubble load-use via Rs1
    tbl.push_back(mkv(1, K_LUH, O_LUS));
    tbl.push_back(mkv(1, K_LUH, O_LUS));
    tbl.push_back(mkv(1, K_IDLE, O_NONE));
    // non-hazards
    tbl.push_back(mkv(1, K_LUH_R0, O_NONE));
    tbl.push_back(mkv(1, K_LUH_NOUSE, O_NONE));
    tbl.push_back(mkv(1, K_LUH_NOWR, O_NONE));
    // via Rs2; second bubble is not re-evaluated from luh
    tbl.push_back(mkv(1, K_LUH_RS2, O_LUS));
    tbl.push_back(mkv(1, K_IDLE, O_LUS));
    tbl.push_back(mkv(1, K_IDLE, O_NONE));
    // branch beats load-use
    tbl.push_back(mkv(1, K_BR_LUH, O_BR));
    tbl.push_back(mkv(1, K_IDLE, O_NONE));
    // branch inside LOAD_STALL cancels remaining bubbles
    tbl.push_back(mkv(1, K_LUH, O_LUS));
    tbl.push_back(mkv(1, K_BR, O_BR));
    tbl.push_back(mkv(1, K_IDLE, O_NONE));
    // three wait cycles then ready: four frozen cycles
    tbl.push_back(mkv(1, K_MWAIT, O_FRZ));
    tbl.push_back(mkv(1, K_MWAIT, O_FRZ));
    tbl.push_back(mkv(1, K_MWAIT, O_FRZ));
    tbl.push_back(mkv(1, K_MRDY, O_FRZ));
    tbl.push_back(mkv(1, K_IDLE, O_NONE));
    tbl.push_back(mkv(1, K_MRDY, O_NONE));
    // wait inside LOAD_STALL restores the remaining bubble
    tbl.push_back(mkv(1, K_LUH, O_LUS));
    tbl.push_back(mkv(1, K_MWAIT, O_FRZ));
    tbl.push_back(mkv(1, K_MRDY, O_FRZ));
    tbl.push_back(mkv(1, K_IDLE, O_LUS));
    tbl.push_back(mkv(1, K_IDLE, O_NONE));
    // halt beats memory wait, then sticks
    tbl.push_back(mkv(1, K_HALT_MWAIT, O_FRZ));
    tbl.push_back(mkv(1, K_IDLE, O_HLT));
    tbl.push_back(mkv(1, K_BR_LUH, O_HLT));
    tbl.push_back(mkv(0, K_IDLE, O_NONE));
    tbl.push_back(mkv(1, K_IDLE, O_NONE));
    // halt mid LOAD_STALL
    tbl.push_back(mkv(1, K_LUH, O_LUS));
    tbl.push_back(mkv(1, K_HALT, O_FRZ));
    tbl.push_back(mkv(1, K_IDLE, O_HLT));
    tbl.push_back(mkv(0, K_IDLE, O_NONE));
    tbl.push_back(mkv(1, K_IDLE, O_NONE));
    // timeout: detect cycle + 4 wait cycles, then sticky halt + timeout
    for (int i = 0; i < 5; i++) tbl.push_back(mkv(1, K_MWAIT, O_FRZ));
    tbl.push_back(mkv(1, K_MWAIT, O_TMO));
    tbl.push_back(mkv(1, K_IDLE, O_TMO));
    tbl.push_back(mkv(1, K_BR_LUH, O_TMO));
    tbl.push_back(mkv(0, K_IDLE, O_NONE));
    tbl.push_back(mkv(1, K_IDLE, O_NONE));
    // halt ignored while frozen
    tbl.push_back(mkv(1, K_MWAIT, O_FRZ));
    tbl.push_back(mkv(1, K_HALT_MWAIT, O_FRZ));
    tbl.push_back(mkv(1, K_MRDY, O_FRZ));
    tbl.push_back(mkv(1, K_IDLE, O_NONE));
    // reset aborts a wait and a stall
    tbl.push_back(mkv(1, K_MWAIT, O_FRZ));
    tbl.push_back(mkv(0, K_MWAIT, O_NONE));
    tbl.push_back(mkv(1, K_IDLE, O_NONE));
    tbl.push_back(mkv(1, K_LUH, O_LUS));
    tbl.push_back(mkv(0, K_LUH, O_NONE));
    tbl.push_back(mkv(1, K_IDLE, O_NONE));

    for (int i = 0; i < tbl.size(); i++)
      run_row("vec", i, tbl[i].rst_n, tbl[i].kind, tbl[i].exp);

    // Hand-written: hold the memory busy and count cycles until halted.
    n = 0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      apply(K_MWAIT);
      @(negedge clk);
      if (hif.halted) done = 1'b1;
      else n++;
    end
    check("tmo_cycles", 0, 32'(n), 32'd5);
    check("tmo_flag", 0, 32'(hif.mem_timeout), 32'd1);
    run_row("tmo_rst", 0, 1'b0, K_IDLE, O_NONE);
    run_row("tmo_rst", 1, 1'b1, K_IDLE, O_NONE);

`ifdef HAZ_PERF_CNT_EN
    run_row("perf", 0, 1'b0, K_IDLE, O_NONE);
    run_row("perf", 1, 1'b1, K_LUH, O_LUS);
    run_row("perf", 2, 1'b1, K_LUH, O_LUS);
    run_row("perf", 3, 1'b1, K_BR, O_BR);
    run_row("perf", 4, 1'b1, K_MWAIT, O_FRZ);
    run_row("perf", 5, 1'b1, K_MWAIT, O_FRZ);
    run_row("perf", 6, 1'b1, K_MRDY, O_FRZ);
    run_row("perf", 7, 1'b1, K_IDLE, O_NONE);
    check("stall_cycles", 0, stall_cycles, 32'd2);
    check("flush_count", 0, flush_count, 32'd1);
    check("wait_cycles", 0, wait_cycles, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
